// File: rtl/cpu_datapath_pkg.sv
// Shared definitions for the single-cycle 16-bit CPU core: sizes, opcode
// constants, instruction field positions, the default program ROM and the
// hex-to-7-segment table.
package cpu_datapath_pkg;

  // Datapath sizing
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned IMEM_DEPTH = 32;
  localparam int unsigned PC_W       = $clog2(IMEM_DEPTH);
  localparam int unsigned REG_N      = 8;
  localparam int unsigned REG_AW     = 3;
  localparam int unsigned OP_W       = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NIB_W      = 4;

  // Instruction field positions (lsb of each field) and widths
  localparam int unsigned OP_LO   = 12;
  localparam int unsigned RD_LO   = 9;
  localparam int unsigned RS_LO   = 6;
  localparam int unsigned RT_LO   = 3;
  localparam int unsigned IMM9_W  = 9;
  localparam int unsigned IMM6_W  = 6;
  localparam int unsigned ADDR_W  = 12;

  // Opcodes; 4'hC..4'hE decode as NOP
  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OP_W-1:0] OP_AND  = 4'h3;
  localparam logic [OP_W-1:0] OP_OR   = 4'h4;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h5;
  localparam logic [OP_W-1:0] OP_SHL  = 4'h6;
  localparam logic [OP_W-1:0] OP_SHR  = 4'h7;
  localparam logic [OP_W-1:0] OP_LDI  = 4'h8;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h9;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'hA;
  localparam logic [OP_W-1:0] OP_JMP  = 4'hB;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [PC_W-1:0]   pc_t;

  // Register-format view of an instruction word
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [2:0]        unused;
  } instr_t;

  // Default program; unlisted entries are NOP
  //  0 LDI r1,5   1 LDI r2,3   2 ADD r3,r1,r2   3 SUB r4,r1,r2
  //  4 AND r5,r1,r2   5 OR r6,r1,r2   6 ADDI r7,r7,1   7 JMP 6
  localparam word_t DEFAULT_ROM [IMEM_DEPTH] = '{
    0:       16'h8205,
    1:       16'h8403,
    2:       16'h1650,
    3:       16'h2850,
    4:       16'h3A50,
    5:       16'h4C50,
    6:       16'h9FC1,
    7:       16'hB006,
    default: 16'h0000
  };

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Sign-extend the 6-bit immediate of an instruction to the datapath width
  function automatic word_t imm6_sx(input word_t instr);
    return {{(DATA_W-IMM6_W){instr[IMM6_W-1]}}, instr[IMM6_W-1:0]};
  endfunction

  // Zero-extend the 9-bit immediate of an instruction
  function automatic word_t imm9_zx(input word_t instr);
    return DATA_W'(instr[IMM9_W-1:0]);
  endfunction

endpackage

// File: rtl/cpu_datapath_if.sv
// Board-facing I/O of the CPU core: the register-select switches and the
// four 7-segment digit outputs (seg0 = least significant nibble).
//   sw   : 3-bit register select, driven by the board (master)
//   seg* : active-low segment patterns, driven by the core (slave)
interface cpu_datapath_if import cpu_datapath_pkg::*; ();

  logic [REG_AW-1:0] sw;
  logic [SEG_W-1:0]  seg0;
  logic [SEG_W-1:0]  seg1;
  logic [SEG_W-1:0]  seg2;
  logic [SEG_W-1:0]  seg3;

  modport master (
    output sw,
    input  seg0, seg1, seg2, seg3
  );

  modport slave (
    input  sw,
    output seg0, seg1, seg2, seg3
  );

endinterface

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
//   hex : 4-bit value to show
//   seg : segment pattern {g,f,e,d,c,b,a}, 0 = lit
module hex_to_7seg import cpu_datapath_pkg::*; (
  input  logic [NIB_W-1:0] hex,
  output logic [SEG_W-1:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/cpu_datapath.sv
// Single-cycle 16-bit CPU core with internal instruction ROM, an 8x16
// register file (r0 reads as zero) and an ALU. One instruction retires per
// rising clock edge; the register selected by io.sw is shown on four
// 7-segment digits, combinationally from the register file.
//   clk : system clock
//   rst : asynchronous active-low reset (clears PC and all registers)
//   io  : cpu_datapath_if.slave -- sw in, seg0..seg3 out
// Optional build macro CPU_DATAPATH_PC_DISPLAY_EN: sw=0 shows the PC
// (zero-extended) instead of r0.
module cpu_datapath import cpu_datapath_pkg::*; (
  input  logic           clk,
  input  logic           rst,
  cpu_datapath_if.slave  io
);

  pc_t    pc;
  pc_t    pc_nxt;
  word_t  regs [REG_N];

  word_t  instr_word;
  instr_t instr;
  word_t  rs_val;
  word_t  rt_val;
  word_t  rd_val;
  word_t  imm6;

  logic   wr_en;
  word_t  wr_data;

  word_t  disp_val;

  // Instruction fetch and operand read
  assign instr_word = DEFAULT_ROM[pc];
  assign instr      = instr_t'(instr_word);
  assign rs_val     = regs[instr.rs];
  assign rt_val     = regs[instr.rt];
  assign rd_val     = regs[instr.rd];
  assign imm6       = imm6_sx(instr_word);

  // Execute: ALU result, write enable and next PC
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    pc_nxt  = pc + PC_W'(1);
    unique case (instr.op)
      OP_ADD:  begin wr_en = 1'b1; wr_data = rs_val + rt_val; end
      OP_SUB:  begin wr_en = 1'b1; wr_data = rs_val - rt_val; end
      OP_AND:  begin wr_en = 1'b1; wr_data = rs_val & rt_val; end
      OP_OR:   begin wr_en = 1'b1; wr_data = rs_val | rt_val; end
      OP_XOR:  begin wr_en = 1'b1; wr_data = rs_val ^ rt_val; end
      OP_SHL:  begin wr_en = 1'b1; wr_data = {rs_val[DATA_W-2:0], 1'b0}; end
      OP_SHR:  begin wr_en = 1'b1; wr_data = {1'b0, rs_val[DATA_W-1:1]}; end
      OP_LDI:  begin wr_en = 1'b1; wr_data = imm9_zx(instr_word); end
      OP_ADDI: begin wr_en = 1'b1; wr_data = rs_val + imm6; end
      OP_BEQ: begin
        // Truncating the sign-extended offset gives modulo-IMEM_DEPTH wrap
        if (rd_val == rs_val) pc_nxt = pc + PC_W'(1) + PC_W'(imm6);
      end
      OP_JMP:  pc_nxt = PC_W'(instr_word[ADDR_W-1:0]);
      OP_HALT: pc_nxt = pc;
      default: ;
    endcase
    // r0 is hardwired to zero
    if (instr.rd == '0) wr_en = 1'b0;
  end

  // PC and register file state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= '0;
      for (int i = 0; i < int'(REG_N); i++) regs[i] <= '0;
    end else begin
      pc <= pc_nxt;
      if (wr_en) regs[instr.rd] <= wr_data;
    end
  end

  // Display source select
  always_comb begin
    disp_val = regs[io.sw];
`ifdef CPU_DATAPATH_PC_DISPLAY_EN
    if (io.sw == '0) disp_val = DATA_W'(pc);
`endif
  end

  hex_to_7seg u_hex0 (.hex(disp_val[3:0]),   .seg(io.seg0));
  hex_to_7seg u_hex1 (.hex(disp_val[7:4]),   .seg(io.seg1));
  hex_to_7seg u_hex2 (.hex(disp_val[11:8]),  .seg(io.seg2));
  hex_to_7seg u_hex3 (.hex(disp_val[15:12]), .seg(io.seg3));

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath. The reference model describes what
// the default program leaves in each register after n retired instructions,
// and the display model maps that value onto active-low segment digits.
module tb_cpu_datapath;

  logic clk;
  logic rst;
  int unsigned n_edges;
  int unsigned errors;
  int unsigned checks;

  cpu_datapath_if io ();

  cpu_datapath dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Program outcome after n instructions: r1..r6 set once at steps 1..6,
  // then r7 increments on every second step from step 7 (loop of ADDI/JMP).
  function automatic logic [15:0] model_pc(input int unsigned n);
    if (n <= 6) return 16'(n);
    return (n % 2 == 1) ? 16'd7 : 16'd6;
  endfunction

  function automatic logic [15:0] model_val(input int unsigned s, input int unsigned n);
    case (s)
`ifdef CPU_DATAPATH_PC_DISPLAY_EN
      0: return model_pc(n);
`else
      0: return 16'd0;
`endif
      1: return (n >= 1) ? 16'd5 : 16'd0;
      2: return (n >= 2) ? 16'd3 : 16'd0;
      3: return (n >= 3) ? 16'd8 : 16'd0;
      4: return (n >= 4) ? 16'd2 : 16'd0;
      5: return (n >= 5) ? 16'd1 : 16'd0;
      6: return (n >= 6) ? 16'd7 : 16'd0;
      default: return (n >= 7) ? 16'((n - 5) / 2) : 16'd0;
    endcase
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Select a register, let the display settle, compare all four digits
  task automatic check(input string tag, input int unsigned s);
    logic [15:0] v;
    logic [27:0] exp_seg;
    logic [27:0] obs_seg;
    io.sw = 3'(s);
    #1;
    v       = model_val(s, rst ? n_edges : 0);
    exp_seg = {hex7(v[15:12]), hex7(v[11:8]), hex7(v[7:4]), hex7(v[3:0])};
    obs_seg = {io.seg3, io.seg2, io.seg1, io.seg0};
    checks++;
    assert (obs_seg === exp_seg) else begin
      errors++;
      $error("FAIL %s sw=%0d n=%0d observed=%h expected=%h (value %h)",
             tag, s, n_edges, obs_seg, exp_seg, v);
    end
  endtask

  // Retire n instructions, then park at the falling edge
  task automatic run(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      n_edges++;
    end
    @(negedge clk);
  endtask

  // Assert reset between edges, check immediate clear, release later
  task automatic mid_reset(input string tag, input int unsigned s);
    #3;
    rst = 1'b0;
    n_edges = 0;
    check(tag, s);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    n_edges = 0;
    rst     = 1'b0;
    io.sw   = '0;

    // Reset held: every register reads zero
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 8; s++) check("reset", s);

    // First run: loads, ALU results, loop counter
    rst = 1'b1;
    run(3);
    check("ldi_r1", 1);
    check("ldi_r2", 2);
    run(3);
    for (int s = 3; s < 7; s++) check("alu", s);
    run(1);
    check("loop_n7", 7);
    check("r0_n7", 0);
    run(1);
    check("loop_n8", 7);
    check("r0_n8", 0);
    run(7);
    check("loop_n15", 7);

    // Asynchronous reset mid-run, then the same sequence again
    mid_reset("async_rst", 7);
    check("async_rst_r3", 3);
    run(3);
    check("rerun_r1", 1);
    check("rerun_r2", 2);
    run(3);
    for (int s = 3; s < 7; s++) check("rerun_alu", s);

    // Randomized run lengths, selects and occasional resets
    for (int it = 0; it < 24; it++) begin
      run($urandom_range(1, 12));
      for (int k = 0; k < 3; k++) check("rand", $urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) mid_reset("rand_rst", $urandom_range(0, 7));
    end

    // Loop counter at 25 instructions after a clean restart
    mid_reset("pre_n25", 7);
    run(25);
    check("loop_n25", 7);
    check("r0_n25", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Single-cycle 16-bit CPU core for an FPGA board.
- Contains a PC, an internal instruction ROM, an 8x16 register file and an ALU.
- A 3-bit switch input selects one register. That register is shown as four hex digits on four 7-segment displays.
- Top-level block; the only inputs are the board clock, reset and switches.

Parameters:
- DATA_W, 16, datapath and register width.
- IMEM_DEPTH, 32, instruction ROM entries; PC width = clog2(IMEM_DEPTH) = 5.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- sw  in  3  register select for the display, r0..r7.
- seg0  out  7  hex digit of selected register bits [3:0].
- seg1  out  7  hex digit of bits [7:4].
- seg2  out  7  hex digit of bits [11:8].
- seg3  out  7  hex digit of bits [15:12].

Behaviour:
- Reset: while rst=0, PC=0 and r0..r7=0, so every segment output shows "0" (7'b1000000).
- One instruction retires per rising edge after reset is released.
- Register write-back and PC update happen on the same edge.
- Instruction format: [15:12] opcode, [11:9] rd, [8:6] rs, [5:3] rt.
  - imm9 = [8:0], zero-extended.
  - imm6 = [5:0], sign-extended.
  - addr = [11:0], truncated to the PC width.
- Opcodes:
  - 0 NOP.
  - 1 ADD rd=rs+rt.
  - 2 SUB rd=rs-rt.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SHL rd=rs<<1.
  - 7 SHR rd=rs>>1 (logical).
  - 8 LDI rd=imm9.
  - 9 ADDI rd=rs+imm6.
  - A BEQ: if reg[rd]==reg[rs] then PC=PC+1+imm6.
  - B JMP: PC=addr.
  - C-E: NOP.
  - F HALT: PC holds; no writes.
- Arithmetic: all results are 16-bit and wrap modulo 2^16; there are no flags.
- r0 is hardwired to zero; writes to it are discarded.
- PC increments modulo IMEM_DEPTH; branch targets wrap the same way.
- ROM entries not listed in the default program are 0 (NOP).
- Default program:
  - 0 LDI r1,5
  - 1 LDI r2,3
  - 2 ADD r3,r1,r2
  - 3 SUB r4,r1,r2
  - 4 AND r5,r1,r2
  - 5 OR r6,r1,r2
  - 6 ADDI r7,r7,1
  - 7 JMP 6
- Display:
  - Purely combinational from the register file and sw; a change of sw is visible in the same cycle.
  - Segments are active-low, bit order {g,f,e,d,c,b,a}.
  - Encodings:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011
    - C=1000110, d=0100001, E=0000110, F=0001110
- Reset asserted mid-program: all state clears immediately (asynchronous). On release, execution restarts from PC 0.

Optional Feature:
- Macro CPU_DATAPATH_PC_DISPLAY_EN.
- When defined: sw=0 displays the PC, zero-extended to 16 bits, instead of r0.
- When undefined: sw=0 displays r0, which always reads 0000.

Decomposition:
- Package cpu_datapath_pkg holds:
  - the opcode constants;
  - the field bit positions;
  - the default program ROM constant;
  - the 16-entry hex-to-segment table.
- One sub-module, hex_to_7seg (4-bit in, 7-bit active-low out), instantiated four times.
- ALU, register file and PC stay inline in cpu_datapath.

Test Plan:
- Reset: hold rst=0 for 2 cycles with sw=0..7 -> all seg outputs read 1000000 for every sw.
- Load: release reset, run 3 edges, sw=1 -> 0005 (seg0=0010010); sw=2 -> 0003.
- ALU: after 6 edges -> sw=3 shows 0008, sw=4 shows 0002, sw=5 shows 0001, sw=6 shows 0007.
- Loop counter: after N edges (N>=7), sw=7 shows floor((N-5)/2); N=7 -> 0001, N=25 -> 000A (seg0=0001000).
- Async reset mid-run: assert rst=0 between edges at N=15 -> r7 reads 0000 immediately without a clock edge. After release the ALU values reappear at the same counts as the first run.
- r0 / optional feature: sw=0 shows 0000 always without the macro. With CPU_DATAPATH_PC_DISPLAY_EN, after 7 edges it shows 0007; after 8 edges it shows 0006.
